// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for a single BRAM port: round-robin with a per-grant burst limit.
// Define BRAM_ARB_FIXED_PRIO_EN to give requester 0 strict priority instead.
module bram_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rq0_req,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [3:0]        rq0_W_req,
    input  logic [DATA_W-1:0] rq0_W_data,
    output logic              rq0_gnt,
    output logic              rq0_R_valid,
    output logic [DATA_W-1:0] rq0_R_data,
    input  logic              rq1_req,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [3:0]        rq1_W_req,
    input  logic [DATA_W-1:0] rq1_W_data,
    output logic              rq1_gnt,
    output logic              rq1_R_valid,
    output logic [DATA_W-1:0] rq1_R_data,
    output logic              m_en,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_W_req,
    output logic [DATA_W-1:0] m_W_data,
    input  logic [DATA_W-1:0] m_R_data
);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    localparam logic [7:0] MaxCnt = 8'(MAX_BURST);

    state_e            state_q, state_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_owner_q, rd_owner_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              acc0, acc1;
    logic [7:0]        cnt_inc;
`ifndef BRAM_ARB_FIXED_PRIO_EN
    logic              ptr_q, ptr_d;       // last owner to release the port
    logic              served_q, served_d; // no owner yet since reset: requester 0 first
`endif

    assign rq0_gnt = (state_q == StGnt0);
    assign rq1_gnt = (state_q == StGnt1);
    assign acc0    = rq0_gnt & rq0_req;
    assign acc1    = rq1_gnt & rq1_req;
    assign cnt_inc = (burst_cnt_q >= MaxCnt) ? MaxCnt : burst_cnt_q + 8'd1;

    always_comb begin
        m_en     = 1'b0;
        m_addr   = '0;
        m_W_req  = '0;
        m_W_data = '0;
        if (acc0) begin
            m_en     = 1'b1;
            m_addr   = rq0_addr;
            m_W_req  = rq0_W_req;
            m_W_data = rq0_W_data;
        end else if (acc1) begin
            m_en     = 1'b1;
            m_addr   = rq1_addr;
            m_W_req  = rq1_W_req;
            m_W_data = rq1_W_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rq0_req && rq1_req) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
                    state_d = StGnt0;
`else
                    state_d = (served_q && !ptr_q) ? StGnt1 : StGnt0;
`endif
                end else if (rq0_req) begin
                    state_d = StGnt0;
                end else if (rq1_req) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!rq0_req) begin
                    state_d = rq1_req ? StGnt1 : StIdle;
                end
`ifndef BRAM_ARB_FIXED_PRIO_EN
                else if (cnt_inc == MaxCnt && rq1_req) begin
                    state_d = StGnt1;
                end
`endif
            end
            StGnt1: begin
                if (!rq1_req) begin
                    state_d = rq0_req ? StGnt0 : StIdle;
                end
`ifdef BRAM_ARB_FIXED_PRIO_EN
                else if (rq0_req) begin
                    state_d = StGnt0;
                end
`else
                else if (cnt_inc == MaxCnt && rq0_req) begin
                    state_d = StGnt0;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        if (state_d != state_q) begin
            burst_cnt_d = 8'd0;
        end else if (acc0 || acc1) begin
            burst_cnt_d = cnt_inc;
        end else begin
            burst_cnt_d = burst_cnt_q;
        end
    end

`ifndef BRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        ptr_d    = ptr_q;
        served_d = served_q;
        if (state_q == StGnt0 && state_d != StGnt0) begin
            ptr_d    = 1'b0;
            served_d = 1'b1;
        end else if (state_q == StGnt1 && state_d != StGnt1) begin
            ptr_d    = 1'b1;
            served_d = 1'b1;
        end
    end
`endif

    // Owner tag is captured with the read, so data returning after a handover still
    // reaches the requester that issued it.
    assign rd_pend_d   = (acc0 && rq0_W_req == 4'b0000) || (acc1 && rq1_W_req == 4'b0000);
    assign rd_owner_d  = acc1;
    assign rq0_R_valid = rd_pend_q & ~rd_owner_q;
    assign rq1_R_valid = rd_pend_q & rd_owner_q;
    assign rq0_R_data  = rq0_R_valid ? m_R_data : rdata0_q;
    assign rq1_R_data  = rq1_R_valid ? m_R_data : rdata1_q;
    assign rdata0_d    = rq0_R_data;
    assign rdata1_d    = rq1_R_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            burst_cnt_q <= 8'd0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_owner_q  <= rd_owner_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

`ifndef BRAM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q    <= 1'b0;
            served_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            served_q <= served_d;
        end
    end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: a rule-level reference model predicts each cycle's
// outputs into a queue that a negedge monitor pops and compares.
module tb_bram_port_arbiter;

    localparam int MB = 4;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    localparam bit Fixed = 1'b1;
`else
    localparam bit Fixed = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rq0_req, rq1_req;
    logic [31:0] rq0_addr, rq1_addr, rq0_W_data, rq1_W_data;
    logic [3:0]  rq0_W_req, rq1_W_req;
    logic        rq0_gnt, rq1_gnt, rq0_R_valid, rq1_R_valid;
    logic [31:0] rq0_R_data, rq1_R_data;
    logic        m_en;
    logic [31:0] m_addr, m_W_data, m_R_data;
    logic [3:0]  m_W_req;

    always #5 clk = ~clk;

    bram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .rq0_req(rq0_req), .rq0_addr(rq0_addr), .rq0_W_req(rq0_W_req),
        .rq0_W_data(rq0_W_data), .rq0_gnt(rq0_gnt), .rq0_R_valid(rq0_R_valid),
        .rq0_R_data(rq0_R_data),
        .rq1_req(rq1_req), .rq1_addr(rq1_addr), .rq1_W_req(rq1_W_req),
        .rq1_W_data(rq1_W_data), .rq1_gnt(rq1_gnt), .rq1_R_valid(rq1_R_valid),
        .rq1_R_data(rq1_R_data),
        .m_en(m_en), .m_addr(m_addr), .m_W_req(m_W_req), .m_W_data(m_W_data),
        .m_R_data(m_R_data)
    );

    // Behavioural BRAM: 16 words, read data one cycle after the enable.
    logic [31:0] bram [16];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_W_req == 4'b0000) m_R_data <= bram[m_addr[5:2]];
            else begin
                for (int b = 0; b < 4; b++)
                    if (m_W_req[b]) bram[m_addr[5:2]][8*b +: 8] <= m_W_data[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        g0, g1, en, v0, v1;
        logic [3:0]  wr;
        logic [31:0] addr, wd, d0, d1;
        logic [7:0]  cnt;
    } exp_t;
    exp_t expq[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: owner -1 means nobody holds the port.
    int          own, cnt, last;
    bit          served, pend;
    int          pend_who;
    logic [31:0] pend_data;
    logic [31:0] hold [2];
    logic [31:0] mem [16];

    task automatic model_reset();
        own = -1; cnt = 0; last = 0; served = 0; pend = 0; pend_who = 0;
        pend_data = '0; hold[0] = '0; hold[1] = '0;
    endtask

    // Advance the model by one clock edge using the inputs of the cycle that just ended.
    task automatic model_step();
        bit          r [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic [3:0]  w [2];
        int          nc, nxt, o;
        if (!rst) return;
        r[0] = rq0_req; a[0] = rq0_addr; w[0] = rq0_W_req; d[0] = rq0_W_data;
        r[1] = rq1_req; a[1] = rq1_addr; w[1] = rq1_W_req; d[1] = rq1_W_data;
        if (pend) begin hold[pend_who] = pend_data; pend = 0; end
        nc = cnt;
        if (own >= 0 && r[own]) begin
            if (w[own] == 4'b0000) begin
                pend = 1; pend_who = own; pend_data = mem[a[own][5:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (w[own][b]) mem[a[own][5:2]][8*b +: 8] = d[own][8*b +: 8];
            end
            nc = (cnt + 1 > MB) ? MB : cnt + 1;
        end
        if (own < 0) begin
            if (r[0] && r[1]) nxt = (Fixed || !served) ? 0 : 1 - last;
            else if (r[0]) nxt = 0;
            else if (r[1]) nxt = 1;
            else nxt = -1;
        end else begin
            o = 1 - own;
            if (!r[own]) nxt = r[o] ? o : -1;
            else if (Fixed) nxt = (own == 1 && r[0]) ? 0 : own;
            else nxt = (nc == MB && r[o]) ? o : own;
        end
        if (nxt != own) begin
            if (own >= 0) begin last = own; served = 1; end
            cnt = 0;
        end else cnt = nc;
        own = nxt;
    endtask

    task automatic model_expect();
        exp_t e;
        bit   acc;
        e = '{default: '0};
        if (rst) begin
            acc  = (own == 0 && rq0_req) || (own == 1 && rq1_req);
            e.g0 = (own == 0);
            e.g1 = (own == 1);
            e.en = acc;
            if (acc && own == 0) begin e.addr = rq0_addr; e.wr = rq0_W_req; e.wd = rq0_W_data; end
            if (acc && own == 1) begin e.addr = rq1_addr; e.wr = rq1_W_req; e.wd = rq1_W_data; end
            e.v0  = pend && pend_who == 0;
            e.v1  = pend && pend_who == 1;
            e.d0  = e.v0 ? pend_data : hold[0];
            e.d1  = e.v1 ? pend_data : hold[1];
            e.cnt = 8'(cnt);
        end
        expq.push_back(e);
    endtask

    task automatic drive(input bit rs, input bit q0, input logic [31:0] a0,
                         input logic [3:0] w0, input logic [31:0] d0, input bit q1,
                         input logic [31:0] a1, input logic [3:0] w1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        model_step();
        rst = rs;
        if (!rs) model_reset();
        rq0_req = q0; rq0_addr = a0; rq0_W_req = w0; rq0_W_data = d0;
        rq1_req = q1; rq1_addr = a1; rq1_W_req = w1; rq1_W_data = d1;
        model_expect();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("rq0_gnt", 32'(rq0_gnt), 32'(e.g0));
            chk("rq1_gnt", 32'(rq1_gnt), 32'(e.g1));
            chk("m_en", 32'(m_en), 32'(e.en));
            chk("m_addr", m_addr, e.addr);
            chk("m_W_req", 32'(m_W_req), 32'(e.wr));
            chk("m_W_data", m_W_data, e.wd);
            chk("rq0_R_valid", 32'(rq0_R_valid), 32'(e.v0));
            chk("rq1_R_valid", 32'(rq1_R_valid), 32'(e.v1));
            chk("rq0_R_data", rq0_R_data, e.d0);
            chk("rq1_R_data", rq1_R_data, e.d1);
            chk("burst_cnt", 32'(dut.burst_cnt_q), 32'(e.cnt));
        end
    end

    function automatic logic [31:0] raddr();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    function automatic logic [3:0] rstrb();
        return ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin bram[i] = '0; mem[i] = '0; end
        m_R_data = '0;
        rst = 1'b0;
        rq0_req = 0; rq0_addr = '0; rq0_W_req = '0; rq0_W_data = '0;
        rq1_req = 0; rq1_addr = '0; rq1_W_req = '0; rq1_W_data = '0;
        model_reset();
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single requester: write then read back.
        repeat (2) drive(1, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0);
        drive(1, 1, 32'h10, 4'h0, 32'h0, 0, 0, 0, 0);
        repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Contention: both hold reads, handovers carry a read in flight.
        repeat (14) drive(1, 1, raddr(), 4'h0, $urandom(), 1, raddr(), 4'h0, $urandom());
        repeat (2) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Uncontended owner: rq1 streams reads past the burst limit.
        repeat (21) drive(1, 0, 0, 0, 0, 1, raddr(), 4'h0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // rq1 owns the port, then rq0 joins and both stay busy.
        repeat (3) drive(1, 0, 0, 0, 0, 1, raddr(), rstrb(), $urandom());
        repeat (50) drive(1, 1, raddr(), rstrb(), $urandom(), 1, raddr(), rstrb(), $urandom());
        repeat (2) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset right after an accepted read, then both request.
        repeat (3) drive(1, 1, raddr(), 4'h0, 0, 0, 0, 0, 0);
        repeat (2) drive(0, 1, raddr(), 4'h0, 0, 1, raddr(), 4'h0, 0);
        repeat (6) drive(1, 1, raddr(), 4'h0, 0, 1, raddr(), 4'h0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 3) != 0), raddr(), rstrb(), $urandom(),
                  ($urandom_range(0, 3) != 0), raddr(), rstrb(), $urandom());
        end
        repeat (3) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
